eq_bin_sequencer: RTL

EQ_BIN_SEQUENCER -- requirements
Module: eq_bin_sequencer

---
 rtl/eq_bin_sequencer_if.sv | 31 +++
 rtl/eq_bin_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/eq_bin_sequencer_if.sv
// Handshake bundle between the FFT source, the equalizer lookup and the IFFT sink
// for eq_bin_sequencer; the slave modport is the sequencer's view.
interface eq_bin_sequencer_if #(
    parameter int SIZE    = 32,
    parameter int SAMPLES = 2048
);
    localparam int IW = $clog2(SAMPLES);

    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic            in_last;
    logic [IW-1:0]   eq_index;
    logic [SIZE-1:0] eq_data;
    logic [SIZE-1:0] eq_result;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;

    modport master (
        output in_valid, in_data, in_last, eq_result, out_ready,
        input  in_ready, eq_index, eq_data, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, eq_result, out_ready,
        output in_ready, eq_index, eq_data, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/eq_bin_sequencer.sv
// Tags FFT bins with their frame index, passes them through the equalizer and buffers
// the results in a 2-entry FIFO. Optional framing check: define EQ_FRAME_CHECK_EN.
module eq_bin_sequencer #(
    parameter int SIZE    = 32,
    parameter int SAMPLES = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    eq_bin_sequencer_if.slave bus,
    output logic [15:0]       frame_count,
    output logic              frame_err
);
    localparam int IW = $clog2(SAMPLES);
    localparam int EW = SIZE + IW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);

    typedef enum logic [0:0] {
        SOF = 1'b0,
        MID = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [15:0]     frame_count_reg, frame_count_next;
    logic            frame_err_reg, frame_err_next;
    logic [1:0]      count_reg, count_next;
    logic            wr_ptr_reg, rd_ptr_reg;
    logic            in_ready_reg;
    logic            accept, pop, at_end, early_last;
    logic [EW-1:0]   head;

    assign accept = bus.in_valid & in_ready_reg;
    assign pop    = bus.out_valid & bus.out_ready;
    assign at_end = (idx_reg == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= SOF;
            idx_reg         <= '0;
            frame_count_reg <= '0;
            frame_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            frame_count_reg <= frame_count_next;
            frame_err_reg   <= frame_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        frame_count_next = frame_count_reg;
        frame_err_next   = frame_err_reg;
        early_last       = 1'b0;
        if (accept) begin
`ifdef EQ_FRAME_CHECK_EN
            // A misplaced in_last is flagged; an early one also restarts framing.
            early_last = bus.in_last & ~at_end;
            if (bus.in_last != at_end) begin
                frame_err_next = 1'b1;
            end
`endif
            if (at_end || early_last) begin
                idx_next   = '0;
                state_next = SOF;
                if (at_end) begin
                    frame_count_next = frame_count_reg + 16'd1;
                end
            end else begin
                idx_next   = idx_reg + 1'b1;
                state_next = MID;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({accept, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // in_ready looks one cycle ahead so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg    <= '0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            in_ready_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            in_ready_reg <= (count_next < 2'd2);
            if (accept) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [EW-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (accept && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= {bus.eq_result, idx_reg, at_end};
                end
            end
        end
    endgenerate

    assign head = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

    assign bus.in_ready  = in_ready_reg;
    assign bus.eq_index  = idx_reg;
    assign bus.eq_data   = bus.in_data;
    assign bus.out_valid = (count_reg != 2'd0);
    assign bus.out_data  = head[EW-1 -: SIZE];
    assign bus.out_index = head[IW:1];
    assign bus.out_last  = head[0];

    assign frame_count = frame_count_reg;
    assign frame_err   = frame_err_reg;
endmodule
